// File: rtl/cpu_core.sv
// Minimal 8-bit accumulator CPU: FETCH/DECODE/EXECUTE controller, four GPRs, Z/C flags.
// Optional debug outputs (dbg_state, dbg_ir) are enabled by defining CPU_DEBUG_PORTS_EN.
module cpu_core (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instruction,
  output logic       LoadIRSig,
  output logic [7:0] acc_out,
  output logic       zero_flag,
  output logic       carry_flag,
  output logic       halted
`ifdef CPU_DEBUG_PORTS_EN
  ,
  output logic [2:0] dbg_state,
  output logic [7:0] dbg_ir
`endif
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StDecode  = 3'd2;
  localparam logic [2:0] StExecute = 3'd3;
  localparam logic [2:0] StHalt    = 3'd4;

  localparam logic [3:0] OpAdd = 4'h1;
  localparam logic [3:0] OpSub = 4'h2;
  localparam logic [3:0] OpAnd = 4'h3;
  localparam logic [3:0] OpOr  = 4'h4;
  localparam logic [3:0] OpSta = 4'h5;
  localparam logic [3:0] OpLda = 4'h6;
  localparam logic [3:0] OpXor = 4'h7;
  localparam logic [3:0] OpNot = 4'h8;
  localparam logic [3:0] OpShl = 4'h9;
  localparam logic [3:0] OpShr = 4'hA;
  localparam logic [3:0] OpInc = 4'hB;
  localparam logic [3:0] OpDec = 4'hC;
  localparam logic [3:0] OpLdi = 4'hD;
  localparam logic [3:0] OpLdh = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  logic [2:0] state_q, state_d;
  logic [7:0] ir_q;
  logic [7:0] acc_q, acc_d;
  logic       z_q, z_d;
  logic       c_q, c_d;
  logic [7:0] opnd_q;
  logic [7:0] regs_q [4];
  logic       reg_we;
  logic       acc_wr;
  logic [8:0] sum;
  logic [8:0] diff;

  logic [3:0] opc;
  logic [3:0] imm;
  assign opc = ir_q[7:4];
  assign imm = ir_q[3:0];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    state_d = StFetch;
      StFetch:   state_d = StDecode;
      StDecode:  state_d = StExecute;
      StExecute: state_d = (opc == OpHlt) ? StHalt : StFetch;
      StHalt:    state_d = StHalt;
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    acc_d  = acc_q;
    z_d    = z_q;
    c_d    = c_q;
    reg_we = 1'b0;
    acc_wr = 1'b1;
    // 9-bit ops so bit 8 is carry-out for ADD and borrow for SUB
    sum    = {1'b0, acc_q} + {1'b0, opnd_q};
    diff   = {1'b0, acc_q} - {1'b0, opnd_q};
    case (opc)
      OpAdd: {c_d, acc_d} = sum;
      OpSub: {c_d, acc_d} = diff;
      OpAnd: acc_d = acc_q & opnd_q;
      OpOr:  acc_d = acc_q | opnd_q;
      OpSta: begin
        acc_wr = 1'b0;
        reg_we = 1'b1;
      end
      OpLda: acc_d = opnd_q;
      OpXor: acc_d = acc_q ^ opnd_q;
      OpNot: acc_d = ~acc_q;
      OpShl: begin
        c_d   = acc_q[7];
        acc_d = {acc_q[6:0], 1'b0};
      end
      OpShr: begin
        c_d   = acc_q[0];
        acc_d = {1'b0, acc_q[7:1]};
      end
      OpInc: begin
        c_d   = (acc_q == 8'hFF);
        acc_d = acc_q + 8'd1;
      end
      OpDec: begin
        c_d   = (acc_q == 8'h00);
        acc_d = acc_q - 8'd1;
      end
      OpLdi: acc_d = {4'b0000, imm};
      OpLdh: acc_d = {imm, acc_q[3:0]};
      default: acc_wr = 1'b0;  // NOP and HALT
    endcase
    if (acc_wr) z_d = (acc_d == 8'h00);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      ir_q    <= 8'h00;
      acc_q   <= 8'h00;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      opnd_q  <= 8'h00;
      for (int i = 0; i < 4; i++) regs_q[i] <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == StFetch) ir_q <= instruction;
      if (state_q == StDecode) opnd_q <= regs_q[ir_q[1:0]];
      if (state_q == StExecute) begin
        acc_q <= acc_d;
        z_q   <= z_d;
        c_q   <= c_d;
        if (reg_we) regs_q[ir_q[1:0]] <= acc_q;
      end
    end
  end

  assign LoadIRSig  = (state_q == StFetch);
  assign halted     = (state_q == StHalt);
  assign acc_out    = acc_q;
  assign zero_flag  = z_q;
  assign carry_flag = c_q;

`ifdef CPU_DEBUG_PORTS_EN
  assign dbg_state = state_q;
  assign dbg_ir    = ir_q;
`endif

endmodule

// File: tb/tb_cpu_core.sv
// Table-driven bench for cpu_core: instructions are presented on each LoadIRSig pulse and
// ACC/Z/C are compared after writeback, plus halt and reset-abort sequences.
module tb_cpu_core;

  logic       clk;
  logic       reset;
  logic [7:0] instruction;
  logic       LoadIRSig;
  logic [7:0] acc_out;
  logic       zero_flag;
  logic       carry_flag;
  logic       halted;
`ifdef CPU_DEBUG_PORTS_EN
  logic [2:0] dbg_state;
  logic [7:0] dbg_ir;
`endif

  cpu_core dut (
    .clk        (clk),
    .reset      (reset),
    .instruction(instruction),
    .LoadIRSig  (LoadIRSig),
    .acc_out    (acc_out),
    .zero_flag  (zero_flag),
    .carry_flag (carry_flag),
    .halted     (halted)
`ifdef CPU_DEBUG_PORTS_EN
    ,
    .dbg_state  (dbg_state),
    .dbg_ir     (dbg_ir)
`endif
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  typedef struct {
    logic [7:0] ins;
    logic [7:0] acc;
    logic       z;
    logic       c;
  } vec_t;

  vec_t vecs [33];
  int   n_pass;
  int   n_total;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  // Present one instruction at the FETCH cycle and return at the next FETCH (after writeback).
  task automatic run_instr(input logic [7:0] ins);
    int waited;
    waited = 0;
    while (LoadIRSig !== 1'b1 && waited < 6) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("fetch_seen_%02h", ins), {15'd0, LoadIRSig}, 16'd1);
    instruction = ins;
    @(negedge clk);
    instruction = 8'hF0;  // junk outside FETCH must be ignored
    @(negedge clk);
    @(negedge clk);
    instruction = 8'h00;
  endtask

  initial begin
    int highs;
    n_pass = 0;
    n_total = 0;
    vecs[0]  = '{8'hD1, 8'h01, 1'b0, 1'b0};
    vecs[1]  = '{8'h51, 8'h01, 1'b0, 1'b0};
    vecs[2]  = '{8'hD2, 8'h02, 1'b0, 1'b0};
    vecs[3]  = '{8'h11, 8'h03, 1'b0, 1'b0};
    vecs[4]  = '{8'hDF, 8'h0F, 1'b0, 1'b0};
    vecs[5]  = '{8'hEF, 8'hFF, 1'b0, 1'b0};
    vecs[6]  = '{8'hB0, 8'h00, 1'b1, 1'b1};
    vecs[7]  = '{8'hC0, 8'hFF, 1'b0, 1'b1};
    vecs[8]  = '{8'hD3, 8'h03, 1'b0, 1'b1};
    vecs[9]  = '{8'h56, 8'h03, 1'b0, 1'b1};
    vecs[10] = '{8'hD1, 8'h01, 1'b0, 1'b1};
    vecs[11] = '{8'h22, 8'hFE, 1'b0, 1'b1};
    vecs[12] = '{8'h72, 8'hFD, 1'b0, 1'b1};
    vecs[13] = '{8'h81, 8'h02, 1'b0, 1'b1};
    vecs[14] = '{8'h91, 8'h04, 1'b0, 1'b0};
    vecs[15] = '{8'hA0, 8'h02, 1'b0, 1'b0};
    vecs[16] = '{8'hA0, 8'h01, 1'b0, 1'b0};
    vecs[17] = '{8'hA0, 8'h00, 1'b1, 1'b1};
    vecs[18] = '{8'h00, 8'h00, 1'b1, 1'b1};
    vecs[19] = '{8'hD8, 8'h08, 1'b0, 1'b1};
    vecs[20] = '{8'h35, 8'h00, 1'b1, 1'b1};
    vecs[21] = '{8'h4E, 8'h03, 1'b0, 1'b1};
    vecs[22] = '{8'hD0, 8'h00, 1'b1, 1'b1};
    vecs[23] = '{8'h61, 8'h01, 1'b0, 1'b1};
    vecs[24] = '{8'hDF, 8'h0F, 1'b0, 1'b1};
    vecs[25] = '{8'hEF, 8'hFF, 1'b0, 1'b1};
    vecs[26] = '{8'h11, 8'h00, 1'b1, 1'b1};
    vecs[27] = '{8'hD4, 8'h04, 1'b0, 1'b1};
    vecs[28] = '{8'h21, 8'h03, 1'b0, 1'b0};
    vecs[29] = '{8'h50, 8'h03, 1'b0, 1'b0};
    vecs[30] = '{8'hD0, 8'h00, 1'b1, 1'b0};
    vecs[31] = '{8'h60, 8'h03, 1'b0, 1'b0};
    vecs[32] = '{8'hC0, 8'h02, 1'b0, 1'b0};

    reset = 1'b1;
    instruction = 8'h00;
    #5;
    check("rst_loadir", {15'd0, LoadIRSig}, 16'd0);
    check("rst_halted", {15'd0, halted}, 16'd0);
    check("rst_acc_zc", {6'd0, acc_out, zero_flag, carry_flag}, 16'd0);
`ifdef CPU_DEBUG_PORTS_EN
    check("rst_dbg", {5'd0, dbg_state, dbg_ir}, 16'd0);
`endif
    #5 reset = 1'b0;

    // LoadIRSig cadence: first pulse one clk after release, then 1 high of every 3
    @(negedge clk); check("ldir_c1", {15'd0, LoadIRSig}, 16'd1);
    @(negedge clk); check("ldir_c2", {15'd0, LoadIRSig}, 16'd0);
    @(negedge clk); check("ldir_c3", {15'd0, LoadIRSig}, 16'd0);
    @(negedge clk); check("ldir_c4", {15'd0, LoadIRSig}, 16'd1);

    for (int i = 0; i < 33; i++) begin
      run_instr(vecs[i].ins);
      check($sformatf("vec%0d_%02h", i, vecs[i].ins), {6'd0, acc_out, zero_flag, carry_flag},
            {6'd0, vecs[i].acc, vecs[i].z, vecs[i].c});
    end

    // HALT: stays halted, no more fetches, ACC preserved
    run_instr(8'hF0);
    check("halt_set", {15'd0, halted}, 16'd1);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (LoadIRSig) highs++;
    end
    check("halt_no_fetch", highs[15:0], 16'd0);
    check("halt_still", {15'd0, halted}, 16'd1);
    check("halt_acc_kept", {6'd0, acc_out, zero_flag, carry_flag}, {6'd0, 8'h02, 1'b0, 1'b0});

    #10 reset = 1'b1;
    #1;
    check("halt_rst_halted", {15'd0, halted}, 16'd0);
    check("halt_rst_acc", {7'd0, acc_out, zero_flag}, 16'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("resume_fetch", {15'd0, LoadIRSig}, 16'd1);
`ifdef CPU_DEBUG_PORTS_EN
    check("resume_dbg_state", {13'd0, dbg_state}, 16'd1);
`endif

    // Reset in EXECUTE of ADD aborts writeback and clears registers
    run_instr(8'hD5);
    run_instr(8'h51);
    run_instr(8'hD7);
    check("pre_abort_acc", {6'd0, acc_out, zero_flag, carry_flag}, {6'd0, 8'h07, 1'b0, 1'b0});
    instruction = 8'h11;
    @(negedge clk);
    instruction = 8'h00;
    @(negedge clk);
    #10 reset = 1'b1;
    #1;
    check("abort_acc_zc", {6'd0, acc_out, zero_flag, carry_flag}, 16'd0);
    check("abort_loadir", {15'd0, LoadIRSig}, 16'd0);
`ifdef CPU_DEBUG_PORTS_EN
    check("abort_dbg", {5'd0, dbg_state, dbg_ir}, 16'd0);
`endif
    @(posedge clk);
    #1;
    check("abort_no_wb", {6'd0, acc_out, zero_flag, carry_flag}, 16'd0);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    run_instr(8'h61);
    check("abort_r1_cleared", {6'd0, acc_out, zero_flag, carry_flag}, {6'd0, 8'h00, 1'b1, 1'b0});
    run_instr(8'hDA);
    check("post_abort_ldi", {6'd0, acc_out, zero_flag, carry_flag}, {6'd0, 8'h0A, 1'b0, 1'b0});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
